// File: rtl/wavetable_pkg.sv
// wavetable_pkg: shared sizes, FSM state encoding and small voice-index
// helpers for the wavetable load arbiter.
package wavetable_pkg;

  localparam int NUM_VOICES = 4;
  localparam int VOICE_W    = 2;
  localparam int WTB_NUM_W  = 5;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    ARB       = 2'd1,
    ISSUE     = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_e;

  // One-hot lane vector for a voice index.
  function automatic logic [NUM_VOICES-1:0] voice_onehot(input logic [VOICE_W-1:0] v);
    logic [NUM_VOICES-1:0] r;
    r    = '0;
    r[v] = 1'b1;
    return r;
  endfunction

  // Voice index after v, wrapping to 0 after the last voice.
  function automatic logic [VOICE_W-1:0] voice_next(input logic [VOICE_W-1:0] v);
    logic [VOICE_W-1:0] r;
    if (v == VOICE_W'(NUM_VOICES - 1)) begin
      r = '0;
    end else begin
      r = v + VOICE_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: combinational round-robin selector. Returns the first
// set request bit at or after ptr, wrapping modulo N.
module rr_priority_picker #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] index
);

  localparam logic [W:0] N_WIDE = (W + 1)'(N);

  logic [W-1:0] cand;

  // ptr + ofs reduced modulo N; the extra bit holds the unwrapped sum.
  function automatic logic [W-1:0] wrap_add(input logic [W-1:0] base, input logic [W:0] ofs);
    logic [W:0] s;
    s = {1'b0, base} + ofs;
    if (s >= N_WIDE) begin
      s = s - N_WIDE;
    end else begin
      s = s;
    end
    return s[W-1:0];
  endfunction

  // Scan from the farthest offset down so the nearest pending voice wins.
  always_comb begin
    found = 1'b0;
    index = '0;
    cand  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand  = wrap_add(ptr, (W + 1)'(i));
      found = found | req[cand];
      index = req[cand] ? cand : index;
    end
  end

endmodule

// File: rtl/wavetable_load_arbiter.sv
// wavetable_load_arbiter: shares the single wavetable loader among the voices.
// Requests are latched per voice, granted round-robin, issued one at a time,
// and the loaded table number is recorded per voice for the mixer.
// Optional build macro WTB_SKIP_RELOAD_EN: a grant whose voice already holds
// the requested table completes immediately without touching the loader.
module wavetable_load_arbiter
  import wavetable_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_VOICES-1:0]           voice_req,
  input  logic [NUM_VOICES*WTB_NUM_W-1:0] voice_wtb_num,
  output logic [NUM_VOICES-1:0]           voice_done,
  output logic [NUM_VOICES-1:0]           loaded_valid,
  output logic [NUM_VOICES*WTB_NUM_W-1:0] loaded_wtb_num,
  output logic                            busy,
  output logic [WTB_NUM_W-1:0]            ldr_wtb_num,
  output logic [VOICE_W-1:0]              ldr_voice_num,
  output logic                            ldr_wtb_load,
  input  logic                            ldr_done,
  input  logic [WTB_NUM_W-1:0]            ldr_done_wtb_num,
  input  logic                            ldr_idle
);

  arb_state_e             state;
  logic [NUM_VOICES-1:0]  pending;
  logic [WTB_NUM_W-1:0]   pend_wtb [NUM_VOICES];
  logic [VOICE_W-1:0]     rr_ptr;
  logic [VOICE_W-1:0]     gnt_voice;

  logic                   pick_found;
  logic [VOICE_W-1:0]     pick_idx;
  logic [WTB_NUM_W-1:0]   pick_wtb;
  logic                   take;
  logic                   skip;
  logic [NUM_VOICES-1:0]  grant_clr;
  logic [NUM_VOICES-1:0]  pending_nxt;
`ifdef WTB_SKIP_RELOAD_EN
  logic [WTB_NUM_W-1:0]   pick_loaded_wtb;
`endif

  rr_priority_picker #(
    .N (NUM_VOICES),
    .W (VOICE_W)
  ) u_picker (
    .req   (pending),
    .ptr   (rr_ptr),
    .found (pick_found),
    .index (pick_idx)
  );

  // Grant decision and next pending vector; a fresh request beats a same-cycle grant clear.
  always_comb begin
    take     = (state == ARB) && pick_found;
    pick_wtb = pend_wtb[pick_idx];
`ifdef WTB_SKIP_RELOAD_EN
    pick_loaded_wtb = loaded_wtb_num[pick_idx*WTB_NUM_W +: WTB_NUM_W];
    skip = take && loaded_valid[pick_idx] && (pick_loaded_wtb == pick_wtb);
`else
    skip = 1'b0;
`endif
    if (take) begin
      grant_clr = voice_onehot(pick_idx);
    end else begin
      grant_clr = '0;
    end
    pending_nxt = (pending & ~grant_clr) | voice_req;
  end

  // Request capture: latest requested table number wins while pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        pend_wtb[i] <= '0;
      end
    end else begin
      pending <= pending_nxt;
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (voice_req[i]) begin
          pend_wtb[i] <= voice_wtb_num[i*WTB_NUM_W +: WTB_NUM_W];
        end
      end
    end
  end

  // Arbitration FSM with registered loader strobe, per-voice status and busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= WAIT_IDLE;
      rr_ptr         <= '0;
      gnt_voice      <= '0;
      ldr_wtb_load   <= 1'b0;
      ldr_wtb_num    <= '0;
      ldr_voice_num  <= '0;
      voice_done     <= '0;
      loaded_valid   <= '0;
      loaded_wtb_num <= '0;
      busy           <= 1'b0;
    end else begin
      voice_done   <= '0;
      ldr_wtb_load <= 1'b0;
      case (state)
        WAIT_IDLE: begin
          // The loader may still be finishing work started before a reset.
          if (ldr_idle) begin
            state <= ARB;
            busy  <= |pending_nxt;
          end else begin
            busy  <= 1'b1;
          end
        end
        ARB: begin
          if (take) begin
            rr_ptr <= voice_next(pick_idx);
            if (skip) begin
              voice_done <= voice_onehot(pick_idx);
              busy       <= |pending_nxt;
            end else begin
              gnt_voice              <= pick_idx;
              ldr_voice_num          <= pick_idx;
              ldr_wtb_num            <= pick_wtb;
              ldr_wtb_load           <= 1'b1;
              // Voice mutes while its RAM slice is being rewritten.
              loaded_valid[pick_idx] <= 1'b0;
              state                  <= ISSUE;
              busy                   <= 1'b1;
            end
          end else begin
            busy <= |pending_nxt;
          end
        end
        ISSUE: begin
          state <= WAIT_DONE;
          busy  <= 1'b1;
        end
        WAIT_DONE: begin
          busy <= 1'b1;
          if (ldr_done) begin
            loaded_wtb_num[gnt_voice*WTB_NUM_W +: WTB_NUM_W] <= ldr_done_wtb_num;
            loaded_valid[gnt_voice] <= 1'b1;
            voice_done              <= voice_onehot(gnt_voice);
            state                   <= WAIT_IDLE;
          end
        end
        default: begin
          state <= WAIT_IDLE;
          busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wavetable_load_arbiter.sv
// tb_wavetable_load_arbiter: directed + randomized bench with a loader model
// and a round-robin reference model of pending requests and loaded tables.
`timescale 1ns/1ps
module tb_wavetable_load_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  voice_req;
  logic [19:0] voice_wtb_num;
  logic [3:0]  voice_done;
  logic [3:0]  loaded_valid;
  logic [19:0] loaded_wtb_num;
  logic        busy;
  logic [4:0]  ldr_wtb_num;
  logic [1:0]  ldr_voice_num;
  logic        ldr_wtb_load;
  logic        ldr_done = 1'b0;
  logic [4:0]  ldr_done_wtb_num = 5'd0;
  logic        ldr_idle = 1'b1;

  always #5 clk = ~clk;

  wavetable_load_arbiter dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .voice_req        (voice_req),
    .voice_wtb_num    (voice_wtb_num),
    .voice_done       (voice_done),
    .loaded_valid     (loaded_valid),
    .loaded_wtb_num   (loaded_wtb_num),
    .busy             (busy),
    .ldr_wtb_num      (ldr_wtb_num),
    .ldr_voice_num    (ldr_voice_num),
    .ldr_wtb_load     (ldr_wtb_load),
    .ldr_done         (ldr_done),
    .ldr_done_wtb_num (ldr_done_wtb_num),
    .ldr_idle         (ldr_idle)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state
  bit m_pend [4];
  int m_pwtb [4];
  int m_rr;
  bit m_lv [4];
  int m_lw [4];
  bit m_inflight;
  int m_gv, m_gw;
  int n_loads = 0;
  bit prev_load = 1'b0;
  bit exp_vd_on = 1'b0;
  int exp_vd_v, exp_vd_w;
  bit skip_window = 1'b0;
  bit long_load = 1'b0;

  // Loader model state
  bit ld_busy = 1'b0;
  bit ld_done_ph = 1'b0;
  int ld_cnt = 0;
  int ld_wtb = 0;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [3:0] pack_pend();
    logic [3:0] r;
    for (int k = 0; k < 4; k++) r[k] = m_pend[k];
    return r;
  endfunction

  function automatic logic [3:0] pack_lv();
    logic [3:0] r;
    for (int k = 0; k < 4; k++) r[k] = m_lv[k];
    return r;
  endfunction

  function automatic logic [19:0] pack_lw();
    logic [19:0] r;
    for (int k = 0; k < 4; k++) r[k*5 +: 5] = m_lw[k][4:0];
    return r;
  endfunction

  // Random table number that cannot coincide with what the voice holds or is loading.
  function automatic int pick_wtb(input int v);
    int w;
    w = int'($urandom_range(31, 0));
    for (int k = 0; k < 3; k++) begin
      if (w == m_lw[v] || (m_inflight && m_gv == v && w == m_gw)) w = (w + 1) % 32;
    end
    return w;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_pend[k] = 1'b0; m_pwtb[k] = 0; m_lv[k] = 1'b0; m_lw[k] = 0;
    end
    m_rr = 0;
    m_inflight = 1'b0;
    exp_vd_on = 1'b0;
  endtask

  // Monitor + loader model, evaluated on the falling edge.
  always @(negedge clk) begin
    int v;
    bit hit;
    if (!skip_window && (exp_vd_on || voice_done !== 4'b0000)) begin
      chk("voice_done", {28'd0, voice_done}, exp_vd_on ? (32'd1 << exp_vd_v) : 32'd0);
      if (exp_vd_on) begin
        chk("done_loaded_valid", {31'd0, loaded_valid[exp_vd_v]}, 32'd1);
        chk("done_loaded_wtb", {27'd0, loaded_wtb_num[exp_vd_v*5 +: 5]}, exp_vd_w);
      end
    end
    exp_vd_on = 1'b0;

    if (ldr_wtb_load === 1'b1) begin
      chk("load_strobe_1cyc", {31'd0, prev_load}, 32'd0);
      chk("ldr_idle_at_load", {31'd0, ldr_idle}, 32'd1);
      hit = 1'b0;
      v = 0;
      for (int k = 0; k < 4; k++) begin
        if (!hit && m_pend[(m_rr + k) % 4]) begin
          hit = 1'b1;
          v = (m_rr + k) % 4;
        end
      end
      chk("load_expected", {31'd0, hit}, 32'd1);
      chk("ldr_voice_num", {30'd0, ldr_voice_num}, v);
      chk("ldr_wtb_num", {27'd0, ldr_wtb_num}, m_pwtb[v]);
      chk("loaded_valid_clr", {31'd0, loaded_valid[v]}, 32'd0);
      m_pend[v] = 1'b0;
      m_rr = (v + 1) % 4;
      m_lv[v] = 1'b0;
      m_inflight = 1'b1;
      m_gv = v;
      m_gw = m_pwtb[v];
      n_loads++;
      ld_busy = 1'b1;
      ld_cnt = long_load ? 12 : int'($urandom_range(5, 2));
      ld_wtb = int'(ldr_wtb_num);
      ldr_idle = 1'b0;
    end else if (ld_done_ph) begin
      ld_done_ph = 1'b0;
      ldr_done = 1'b0;
      ldr_idle = 1'b1;
    end else if (ld_busy) begin
      if (ld_cnt == 0) begin
        ld_busy = 1'b0;
        ld_done_ph = 1'b1;
        ldr_done = 1'b1;
        ldr_done_wtb_num = ld_wtb[4:0];
        if (m_inflight) begin
          chk("ldr_hold", {25'd0, ldr_voice_num, ldr_wtb_num}, {25'd0, m_gv[1:0], m_gw[4:0]});
          exp_vd_on = 1'b1;
          exp_vd_v = m_gv;
          exp_vd_w = m_gw;
          m_lv[m_gv] = 1'b1;
          m_lw[m_gv] = m_gw;
          m_inflight = 1'b0;
        end
      end else begin
        ld_cnt--;
      end
    end
    prev_load = (ldr_wtb_load === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [3:0] mask, input logic [19:0] wtbs);
    for (int k = 0; k < 4; k++) begin
      if (mask[k]) begin
        m_pend[k] = 1'b1;
        m_pwtb[k] = int'(wtbs[k*5 +: 5]);
      end
    end
    voice_req = mask;
    voice_wtb_num = wtbs;
    tick();
    voice_req = 4'b0000;
    voice_wtb_num = 20'($urandom);
  endtask

  task automatic wait_loads(input int target);
    int k;
    k = 0;
    while (n_loads < target && k < 100) begin
      tick();
      k++;
    end
    chk("load_timeout", {31'd0, n_loads >= target}, 32'd1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    tick();
    while (busy !== 1'b0 && k < 300) begin
      tick();
      k++;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
    chk("model_drained", {28'd0, pack_pend()}, 32'd0);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    logic [19:0] wt;
    logic [3:0]  mask;
    int base, w;

    rst_n = 1'b0;
    voice_req = 4'b0000;
    voice_wtb_num = 20'd0;
    model_reset();
    tick(); tick(); tick();
    chk("reset_ctl", {24'd0, voice_done, loaded_valid}, 32'd0);
    chk("reset_ldr", {23'd0, busy, ldr_wtb_load, ldr_voice_num, ldr_wtb_num}, 32'd0);
    chk("reset_loaded_wtb", {12'd0, loaded_wtb_num}, 32'd0);
    rst_n = 1'b1;
    tick(); tick();

    // Single request, voice 2 table 7; load strobe two cycles after capture.
    wt = '0; wt[14:10] = 5'd7;
    do_req(4'b0100, wt);
    chk("t1_no_early_load", {31'd0, ldr_wtb_load}, 32'd0);
    tick();
    chk("t1_load_latency", {31'd0, ldr_wtb_load}, 32'd1);
    wait_idle();
    chk("t1_loaded_wtb2", {27'd0, loaded_wtb_num[14:10]}, 32'd7);
    chk("t1_loaded_valid", {28'd0, loaded_valid}, 32'h4);

    // All four voices at once, from a fresh round-robin pointer.
    reset_pulse();
    base = n_loads;
    do_req(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1});
    wait_loads(base + 4);
    wait_idle();
    chk("t2_loads", n_loads - base, 32'd4);
    chk("t2_loaded_wtb", {12'd0, loaded_wtb_num}, {12'd0, 5'd4, 5'd3, 5'd2, 5'd1});
    chk("t2_loaded_valid", {28'd0, loaded_valid}, 32'hF);

    // Voice 1 re-requests while voice 0 loads: one load, latest number.
    base = n_loads;
    wt = '0; wt[4:0] = 5'(pick_wtb(0));
    do_req(4'b0001, wt);
    wait_loads(base + 1);
    wt = '0; wt[9:5] = 5'd3;
    do_req(4'b0010, wt);
    tick();
    wt = '0; wt[9:5] = 5'd9;
    do_req(4'b0010, wt);
    wait_idle();
    chk("t3_loads", n_loads - base, 32'd2);
    chk("t3_v1_wtb", {27'd0, loaded_wtb_num[9:5]}, 32'd9);

    // Voice 3 requests during its own load: reloads after the first done.
    base = n_loads;
    wt = '0; wt[19:15] = 5'(pick_wtb(3));
    do_req(4'b1000, wt);
    wait_loads(base + 1);
    w = pick_wtb(3);
    wt = '0; wt[19:15] = 5'(w);
    do_req(4'b1000, wt);
    wait_loads(base + 2);
    wait_idle();
    chk("t5_loads", n_loads - base, 32'd2);
    chk("t5_v3_wtb", {27'd0, loaded_wtb_num[19:15]}, w);

    // Reset during WAIT_DONE while the loader is still busy.
    long_load = 1'b1;
    base = n_loads;
    wt = '0; wt[14:10] = 5'(pick_wtb(2));
    do_req(4'b0100, wt);
    wait_loads(base + 1);
    tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_mid_ctl", {24'd0, voice_done, loaded_valid}, 32'd0);
    chk("rst_mid_ldr", {23'd0, busy, ldr_wtb_load, ldr_voice_num, ldr_wtb_num}, 32'd0);
    chk("rst_mid_wtb", {12'd0, loaded_wtb_num}, 32'd0);
    tick();
    rst_n = 1'b1;
    long_load = 1'b0;
    wt = '0; wt[9:5] = 5'(pick_wtb(1));
    do_req(4'b0010, wt);
    tick();
    chk("rst_busy_wait_idle", {31'd0, busy}, 32'd1);
    chk("rst_no_load_while_busy", {31'd0, ldr_wtb_load}, 32'd0);
    wait_loads(base + 2);
    wait_idle();
    chk("rst_loads", n_loads - base, 32'd2);
    chk("rst_loaded_valid", {28'd0, loaded_valid}, 32'h2);

    // Same-number reload on voice 0.
    base = n_loads;
    wt = '0; wt[4:0] = 5'd5;
    do_req(4'b0001, wt);
    wait_loads(base + 1);
    wait_idle();
    chk("skip_setup_wtb", {27'd0, loaded_wtb_num[4:0]}, 32'd5);
`ifdef WTB_SKIP_RELOAD_EN
    skip_window = 1'b1;
    do_req(4'b0001, wt);
    chk("skip_done_early", {28'd0, voice_done}, 32'd0);
    tick();
    chk("skip_done", {28'd0, voice_done}, 32'h1);
    chk("skip_valid", {31'd0, loaded_valid[0]}, 32'd1);
    tick();
    chk("skip_done_pulse", {28'd0, voice_done}, 32'd0);
    m_pend[0] = 1'b0;
    m_rr = 1;
    skip_window = 1'b0;
    wait_idle();
    chk("skip_no_load", n_loads - base, 32'd1);
`else
    do_req(4'b0001, wt);
    tick();
    chk("reload_load", {31'd0, ldr_wtb_load}, 32'd1);
    wait_idle();
    chk("reload_loads", n_loads - base, 32'd2);
    chk("reload_wtb", {27'd0, loaded_wtb_num[4:0]}, 32'd5);
`endif

    // Randomized rounds, some with extra requests issued mid-load.
    for (int r = 0; r < 12; r++) begin
      base = n_loads;
      mask = 4'($urandom_range(15, 1));
      wt = '0;
      for (int k = 0; k < 4; k++) wt[k*5 +: 5] = 5'(pick_wtb(k));
      do_req(mask, wt);
      if ($urandom_range(1, 0) == 1) begin
        wait_loads(base + 1);
        mask = 4'($urandom_range(15, 0));
        wt = '0;
        for (int k = 0; k < 4; k++) wt[k*5 +: 5] = 5'(pick_wtb(k));
        do_req(mask, wt);
      end
      wait_idle();
      chk("rand_loaded_valid", {28'd0, loaded_valid}, {28'd0, pack_lv()});
      chk("rand_loaded_wtb", {12'd0, loaded_wtb_num}, {12'd0, pack_lw()});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wavetable_load_arbiter.md
Name: wavetable_load_arbiter

Overview:
- Shares the single wavetable loader between NUM_VOICES voice requesters.
- Latches each voice's wavetable load request and grants them round-robin.
- Issues one load at a time and waits for the loader's completion pulse.
- Keeps a per-voice record of the wavetable currently loaded, which feeds the voice/mixer control logic.

Parameters:
- NUM_VOICES, 4, number of requesting voices; equals the number of wavetable RAM write-enable lanes.
- VOICE_W, 2, voice index width; must equal clog2(NUM_VOICES).
- WTB_NUM_W, 5, wavetable number width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- voice_req  in  NUM_VOICES  per-voice 1-cycle load request strobe.
- voice_wtb_num  in  NUM_VOICES*WTB_NUM_W  requested wavetable number per voice; voice i uses bits [i*WTB_NUM_W +: WTB_NUM_W].
- voice_done  out  NUM_VOICES  1-cycle pulse: the load for that voice has completed.
- loaded_valid  out  NUM_VOICES  voice holds a loaded wavetable.
- loaded_wtb_num  out  NUM_VOICES*WTB_NUM_W  currently loaded wavetable number per voice.
- busy  out  1  a load is outstanding or a request is pending.
- ldr_wtb_num  out  WTB_NUM_W  to loader wtb_num.
- ldr_voice_num  out  VOICE_W  to loader voice_num.
- ldr_wtb_load  out  1  to loader wtb_load; 1-cycle strobe.
- ldr_done  in  1  from loader done.
- ldr_done_wtb_num  in  WTB_NUM_W  from loader done_wtb_num.
- ldr_idle  in  1  from loader idle.

Behaviour:
- Reset values: all outputs 0; pending[] = 0; pend_wtb[] = 0; rr_ptr = 0; state = WAIT_IDLE.
- Request capture, every cycle, in every state:
  - voice_req[i]=1 sets pending[i] and stores voice_wtb_num[i] into pend_wtb[i].
  - A repeat request while pending[i]=1 overwrites pend_wtb[i]; latest wins, and only one load is performed.
  - A grant clearing pending[i] in the same cycle as a new voice_req[i] leaves pending[i]=1 with the new number.
- FSM states:
  - WAIT_IDLE: wait for ldr_idle=1. Entered after reset because the loader may be mid-operation; then go to ARB.
  - ARB: if any pending bit is set, select the first one at or after rr_ptr (wrapping modulo NUM_VOICES) and latch gnt_voice and gnt_wtb. Clear that pending bit, set rr_ptr = gnt_voice+1 (wrapping), and go to ISSUE. Otherwise stay in ARB.
  - ISSUE: assert ldr_wtb_load=1 for exactly one cycle, with ldr_wtb_num=gnt_wtb and ldr_voice_num=gnt_voice. Requires ldr_idle=1, which is guaranteed by the WAIT_IDLE and DONE paths. Go to WAIT_DONE.
  - WAIT_DONE: hold ldr_wtb_num and ldr_voice_num stable. On ldr_done=1:
    - loaded_wtb_num[gnt_voice] <= ldr_done_wtb_num;
    - loaded_valid[gnt_voice] <= 1;
    - voice_done[gnt_voice] pulses the following cycle (registered);
    - go to WAIT_IDLE. The loader returns to idle one cycle after done.
  - ldr_done outside WAIT_DONE is ignored.
- Latency: a request in cycle 0 reaching ARB with no contention gives ldr_wtb_load in cycle 2, counted from the cycle the request is seen in ARB. Arbitration overhead per load is 3 cycles (WAIT_IDLE, ARB, ISSUE).
- loaded_valid[i] is cleared in the cycle its load is issued; the voice must mute while its RAM slice is being rewritten. It is set again on completion.
- busy = (state != ARB) | (|pending).
- Fairness: with all voices requesting continuously, the grant order is 0, 1, 2, 3, 0, …
- Reset mid-load: arbiter state is cleared and any pending requests are lost. The loader finishes on its own, and its done pulse is ignored while in WAIT_IDLE.

Optional Feature:
- Macro: WTB_SKIP_RELOAD_EN.
- Defined: in ARB, if the granted voice has loaded_valid=1 and loaded_wtb_num equal to gnt_wtb:
  - no ISSUE and no loader access;
  - voice_done pulses the next cycle;
  - loaded_valid stays 1;
  - rr_ptr advances as normal;
  - state stays ARB.
- Not defined: every granted request is loaded, even when the number matches.

Decomposition:
- Shared package wavetable_pkg:
  - constants NUM_VOICES, VOICE_W, WTB_NUM_W;
  - FSM state encoding typedef (WAIT_IDLE, ARB, ISSUE, WAIT_DONE, 2 bits).
- One sub-module: rr_priority_picker. Combinational round-robin selector over a NUM_VOICES pending vector with rr_ptr; outputs found and index.

Test Plan:
- Reset, then a single request: voice_req=0100, wtb=7. Expect ldr_wtb_load with voice_num=2 and wtb_num=7, then voice_done=0100 after the loader model's done. Expect loaded_wtb_num[2]=7 and loaded_valid[2]=1.
- All four voices request in the same cycle (wtb 1, 2, 3, 4). Expect loads in order voice 0, 1, 2, 3, each ldr_wtb_load separated by its done, and the correct loaded_wtb_num per voice.
- Voice 1 requests wtb 3, then wtb 9 two cycles later while voice 0 is loading. Expect exactly one load for voice 1, with wtb 9.
- Assert rst_n=0 during WAIT_DONE, release it while the loader is still busy. Expect no ldr_wtb_load until ldr_idle=1, the stray done ignored, and all outputs 0.
- Request voice 3 during its own WAIT_DONE. Expect a second load for voice 3 after the first done, and loaded_valid[3] dropping at the second issue.
- With WTB_SKIP_RELOAD_EN defined and voice 0 holding wtb 5, request wtb 5 on voice 0. Expect no ldr_wtb_load and voice_done[0] 2 cycles later. Without the macro, expect a normal load.
